// File: rtl/axi_lite_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_slave_mem_if
// Brief   : AXI-lite bus bundle (AW/W/B/AR/R) with master and slave views.
// Revision: 1.0
// ============================================================================
interface axi_lite_slave_mem_if;
  logic [63:0] awaddr;
  logic        awvalid;
  logic [3:0]  awid;
  logic [2:0]  awprot;
  logic        awready;
  logic        wvalid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wready;
  logic        bvalid;
  logic        bresp;
  logic        bready;
  logic [63:0] araddr;
  logic [3:0]  arid;
  logic        arvalid;
  logic [2:0]  arprot;
  logic        arready;
  logic        rvalid;
  logic [63:0] rdata;
  logic [3:0]  rid;
  logic        rresp;
  logic        rready;

  modport master (
    output awaddr, awvalid, awid, awprot, wvalid, wdata, wstrb, bready,
    output araddr, arid, arvalid, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rid, rresp
  );

  modport slave (
    input  awaddr, awvalid, awid, awprot, wvalid, wdata, wstrb, bready,
    input  araddr, arid, arvalid, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rid, rresp
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_slave_mem.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_slave_mem
// Brief   : AXI-lite slave scratch RAM, 64-bit byte-strobed, DEPTH words.
// Revision: 1.0
// ============================================================================
module axi_lite_slave_mem #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter bit          SECURE_ONLY = 1'b0
) (
  input  logic                aclk,
  input  logic                arst,
  axi_lite_slave_mem_if.slave axi
);
  localparam int unsigned c_IDX_W = $clog2(DEPTH);
  localparam logic [60:0] c_DEPTH = 61'(DEPTH);

  logic               r_en;
  logic               r_aw_full;
  logic [63:0]        r_aw_addr;
  logic [2:0]         r_aw_prot;
  logic               r_w_full;
  logic [63:0]        r_w_data;
  logic [7:0]         r_w_strb;
  logic               r_bvalid;
  logic               r_bresp;
  logic               r_rvalid;
  logic [63:0]        r_rdata;
  logic [3:0]         r_rid;
  logic               r_rresp;
  logic [63:0]        r_mem [DEPTH];

  logic               w_awready, w_wready, w_arready;
  logic               w_aw_hs, w_w_hs, w_ar_hs;
  logic               w_aw_have, w_w_have, w_commit;
  logic [63:0]        w_aw_addr, w_aw_off, w_w_data;
  logic [2:0]         w_aw_prot;
  logic [7:0]         w_w_strb;
  logic               w_aw_err;
  logic [c_IDX_W-1:0] w_aw_idx;
  logic [63:0]        w_ar_off;
  logic               w_ar_err;
  logic [c_IDX_W-1:0] w_ar_idx;
  logic               w_unused;

  // r_en keeps every ready low until the first edge after reset release.
  assign w_awready = r_en && !r_aw_full;
  assign w_wready  = r_en && !r_w_full;
  assign w_arready = r_en && (!r_rvalid || axi.rready);

  assign w_aw_hs   = axi.awvalid && w_awready;
  assign w_w_hs    = axi.wvalid  && w_wready;
  assign w_ar_hs   = axi.arvalid && w_arready;

  // Bypass the holding registers so a same-edge AW+W pair commits immediately.
  assign w_aw_have = r_aw_full || w_aw_hs;
  assign w_w_have  = r_w_full  || w_w_hs;
  assign w_commit  = w_aw_have && w_w_have && (!r_bvalid || axi.bready);

  assign w_aw_addr = r_aw_full ? r_aw_addr : axi.awaddr;
  assign w_aw_prot = r_aw_full ? r_aw_prot : axi.awprot;
  assign w_w_data  = r_w_full  ? r_w_data  : axi.wdata;
  assign w_w_strb  = r_w_full  ? r_w_strb  : axi.wstrb;

  assign w_aw_off  = w_aw_addr - BASE_ADDR;
  assign w_aw_idx  = w_aw_off[c_IDX_W+2:3];
  assign w_aw_err  = (w_aw_addr < BASE_ADDR) || (w_aw_off[63:3] >= c_DEPTH) ||
                     (SECURE_ONLY && w_aw_prot[1]);

  assign w_ar_off  = axi.araddr - BASE_ADDR;
  assign w_ar_idx  = w_ar_off[c_IDX_W+2:3];
  assign w_ar_err  = (axi.araddr < BASE_ADDR) || (w_ar_off[63:3] >= c_DEPTH) ||
                     (SECURE_ONLY && axi.arprot[1]);

  assign w_unused  = &{1'b0, axi.awid, w_aw_off[2:0], w_aw_prot[0], w_aw_prot[2],
                       w_ar_off[2:0], axi.arprot[0], axi.arprot[2]};

  assign axi.awready = w_awready;
  assign axi.wready  = w_wready;
  assign axi.arready = w_arready;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.rvalid  = r_rvalid;
  assign axi.rdata   = r_rdata;
  assign axi.rid     = r_rid;
  assign axi.rresp   = r_rresp;

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      r_en      <= 1'b0;
      r_aw_full <= 1'b0;
      r_aw_addr <= 64'h0;
      r_aw_prot <= 3'b000;
      r_w_full  <= 1'b0;
      r_w_data  <= 64'h0;
      r_w_strb  <= 8'h00;
      r_bvalid  <= 1'b0;
      r_bresp   <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_aw_hs) begin
        r_aw_addr <= axi.awaddr;
        r_aw_prot <= axi.awprot;
      end
      if (w_w_hs) begin
        r_w_data <= axi.wdata;
        r_w_strb <= axi.wstrb;
      end
      r_aw_full <= w_aw_have && !w_commit;
      r_w_full  <= w_w_have  && !w_commit;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_err;
      end else if (axi.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // A read on the commit edge sees the pre-write word through NBA ordering.
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 64'h0;
      r_rid    <= 4'h0;
      r_rresp  <= 1'b0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rid    <= axi.arid;
      r_rresp  <= w_ar_err;
      r_rdata  <= w_ar_err ? 64'h0 : r_mem[w_ar_idx];
    end else if (axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_commit && !w_aw_err) begin
      for (int i = 0; i < 8; i++) begin
        if (w_w_strb[i]) r_mem[w_aw_idx][8*i +: 8] <= w_w_data[8*i +: 8];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_lite_slave_mem
// Brief   : Directed scoreboard bench for axi_lite_slave_mem.
// Revision: 1.0
// ============================================================================
module tb_axi_lite_slave_mem;
  localparam int          DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h100;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  id;
    logic        e;
  } r_exp_t;

  logic   aclk = 1'b0;
  logic   rst_n = 1'b0;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  logic   bq[$];
  r_exp_t rq[$];
  logic [63:0] mdl [int];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  axi_lite_slave_mem_if bus();

  axi_lite_slave_mem #(
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .SECURE_ONLY(1'b1)
  ) dut (
    .aclk(aclk),
    .arst(rst_n),
    .axi (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_err(input logic [63:0] a, input logic [2:0] p);
    return (a < BASE) || (a >= BASE + 64'(8 * DEPTH)) || p[1];
  endfunction

  task automatic push_w(input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s, input logic [2:0] p);
    logic e;
    int idx;
    logic [63:0] v;
    e = m_err(a, p);
    bq.push_back(e);
    if (!e) begin
      idx = int'((a - BASE) >> 3);
      v = mdl.exists(idx) ? mdl[idx] : 64'h0;
      for (int i = 0; i < 8; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
      mdl[idx] = v;
    end
  endtask

  task automatic push_r(input logic [63:0] a, input logic [3:0] id, input logic [2:0] p);
    r_exp_t r;
    r.e  = m_err(a, p);
    r.id = id;
    r.d  = r.e ? 64'h0 : mdl[int'((a - BASE) >> 3)];
    rq.push_back(r);
  endtask

  task automatic aw_send(input logic [63:0] a, input logic [2:0] p);
    int n = 0;
    bus.awvalid = 1'b1; bus.awaddr = a; bus.awprot = p; bus.awid = 4'h3;
    forever begin
      @(negedge aclk);
      if (bus.awready) break;
      if (++n > 50) begin chk("aw_timeout", 0, 1); break; end
    end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
    forever begin
      @(negedge aclk);
      if (bus.wready) break;
      if (++n > 50) begin chk("w_timeout", 0, 1); break; end
    end
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [63:0] a, input logic [3:0] id, input logic [2:0] p);
    int n = 0;
    bus.arvalid = 1'b1; bus.araddr = a; bus.arid = id; bus.arprot = p;
    forever begin
      @(negedge aclk);
      if (bus.arready) break;
      if (++n > 50) begin chk("ar_timeout", 0, 1); break; end
    end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic write(input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, input logic [2:0] p);
    push_w(a, d, s, p);
    fork
      aw_send(a, p);
      w_send(d, s);
    join
  endtask

  task automatic read(input logic [63:0] a, input logic [3:0] id, input logic [2:0] p);
    push_r(a, id, p);
    ar_send(a, id, p);
  endtask

  // Scoreboard: responses are popped on the cycle their handshake completes.
  always @(negedge aclk) begin
    if (rst_n && bus.bvalid && bus.bready) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", 64'(bus.bresp), 64'(bq.pop_front()));
    end
    if (rst_n && bus.rvalid && bus.rready) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        r_exp_t r;
        r = rq.pop_front();
        chk("rdata", bus.rdata, r.d);
        chk("rid", 64'(bus.rid), 64'(r.id));
        chk("rresp", 64'(bus.rresp), 64'(r.e));
      end
    end
  end

  initial begin
    int c0;
    bus.awaddr = '0; bus.awvalid = 0; bus.awid = '0; bus.awprot = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 1;
    bus.araddr = '0; bus.arid = '0; bus.arvalid = 0; bus.arprot = '0; bus.rready = 1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 64'(bus.awready), 0);
    chk("rst_wready", 64'(bus.wready), 0);
    chk("rst_arready", 64'(bus.arready), 0);
    chk("rst_bvalid", 64'(bus.bvalid), 0);
    chk("rst_rvalid", 64'(bus.rvalid), 0);
    rst_n = 1'b1;
    #1 chk("rel_awready_pre_edge", 64'(bus.awready), 0);
    @(posedge aclk); #1;
    chk("rel_awready", 64'(bus.awready), 1);
    chk("rel_wready", 64'(bus.wready), 1);
    chk("rel_arready", 64'(bus.arready), 1);

    // Basic write/read
    write(BASE + 64'h10, 64'h1122334455667788, 8'hFF, 3'b000);
    chk("basic_bvalid_next", 64'(bus.bvalid), 1);
    read(BASE + 64'h10, 4'd5, 3'b000);
    chk("basic_rvalid_next", 64'(bus.rvalid), 1);
    write(BASE + 64'h00, 64'hCAFEF00D12345678, 8'hFF, 3'b000);

    // W ahead of AW by three cycles
    push_w(BASE + 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 3'b000);
    w_send(64'hAAAAAAAAAAAAAAAA, 8'h0F);
    repeat (3) begin
      @(negedge aclk);
      chk("order_awready", 64'(bus.awready), 1);
      chk("order_wready", 64'(bus.wready), 0);
      chk("order_bvalid", 64'(bus.bvalid), 0);
    end
    @(posedge aclk); #1;
    aw_send(BASE + 64'h10, 3'b000);
    chk("order_bvalid_after_aw", 64'(bus.bvalid), 1);
    read(BASE + 64'h10, 4'd1, 3'b000);

    // Error decode: past end, below base, secure-only
    write(BASE + 64'(8 * DEPTH), 64'hDEADBEEFDEADBEEF, 8'hFF, 3'b000);
    write(BASE + 64'h10, 64'h5555555555555555, 8'hFF, 3'b010);
    read(BASE + 64'h00, 4'd2, 3'b000);
    read(BASE + 64'h10, 4'd3, 3'b000);
    read(64'h0, 4'd4, 3'b000);
    read(BASE + 64'h10, 4'd6, 3'b010);
    read(BASE + 64'(8 * DEPTH), 4'd7, 3'b000);

    // B backpressure with a second pair held in the buffers
    bus.bready = 1'b0;
    write(BASE + 64'(8 * DEPTH) + 64'h8, 64'h0, 8'hFF, 3'b000);
    write(BASE + 64'h28, 64'h0123456789ABCDEF, 8'hFF, 3'b000);
    repeat (4) begin
      @(negedge aclk);
      chk("bp_awready", 64'(bus.awready), 0);
      chk("bp_wready", 64'(bus.wready), 0);
      chk("bp_bvalid", 64'(bus.bvalid), 1);
      chk("bp_bresp", 64'(bus.bresp), 1);
    end
    @(posedge aclk); #1;
    bus.bready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("bp_bvalid_drained", 64'(bus.bvalid), 0);
    chk("bp_awready_free", 64'(bus.awready), 1);

    // R backpressure
    bus.rready = 1'b0;
    read(BASE + 64'h28, 4'd9, 3'b000);
    chk("rbp_rvalid", 64'(bus.rvalid), 1);
    repeat (3) begin
      @(negedge aclk);
      chk("rbp_arready", 64'(bus.arready), 0);
      chk("rbp_rdata", bus.rdata, 64'h0123456789ABCDEF);
      chk("rbp_rid", 64'(bus.rid), 9);
    end
    @(posedge aclk); #1;
    bus.rready = 1'b1;
    @(posedge aclk); #1;

    // Streaming writes and reads
    c0 = cyc;
    for (int i = 0; i < 4; i++)
      write(BASE + 64'h40 + 64'(8 * i), 64'h1000 * 64'(i + 1) + 64'h77, 8'hFF, 3'b000);
    chk("wr_stream_cycles", 64'(cyc - c0), 4);
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      read(BASE + 64'h40 + 64'(8 * (i % 4)), 4'(i + 8), 3'b000);
    chk("rd_stream_cycles", 64'(cyc - c0), 8);

    // Collision: read on the commit edge returns old data, next read new
    push_r(BASE + 64'h48, 4'hA, 3'b000);
    push_w(BASE + 64'h48, 64'hFEEDFACE00000001, 8'hFF, 3'b000);
    fork
      aw_send(BASE + 64'h48, 3'b000);
      w_send(64'hFEEDFACE00000001, 8'hFF);
      ar_send(BASE + 64'h48, 4'hA, 3'b000);
    join
    read(BASE + 64'h48, 4'hB, 3'b000);
    repeat (3) @(posedge aclk);
    #1;
    chk("bq_empty", 64'(bq.size()), 0);
    chk("rq_empty", 64'(rq.size()), 0);

    // Reset mid-operation: pending B and a buffered AW are discarded
    bus.bready = 1'b0;
    write(BASE + 64'h78, 64'h9999, 8'hFF, 3'b000);
    aw_send(BASE + 64'h70, 3'b000);
    @(negedge aclk);
    chk("mid_bvalid", 64'(bus.bvalid), 1);
    chk("mid_awready", 64'(bus.awready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", 64'(bus.bvalid), 0);
    chk("mid_rst_awready", 64'(bus.awready), 0);
    bq.delete();
    @(posedge aclk); #3;
    rst_n = 1'b1;
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    chk("post_awready", 64'(bus.awready), 1);
    push_w(BASE + 64'h70, 64'h4242, 8'hFF, 3'b000);
    w_send(64'h4242, 8'hFF);
    repeat (2) begin
      @(negedge aclk);
      chk("post_no_stale_b", 64'(bus.bvalid), 0);
      chk("post_w_held", 64'(bus.wready), 0);
    end
    @(posedge aclk); #1;
    aw_send(BASE + 64'h70, 3'b000);
    read(BASE + 64'h70, 4'hC, 3'b000);
    repeat (3) @(posedge aclk);
    #1;
    chk("end_bq_empty", 64'(bq.size()), 0);
    chk("end_rq_empty", 64'(rq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- AXI-lite slave memory that terminates the axi_lite_if bus and consumes master-driven AW/W/AR/R-ready/B-ready traffic.
- Returns B and R responses; 64-bit data, byte-strobed, DEPTH words at BASE_ADDR. Bench slave BFM target and on-chip scratch RAM.

Parameters:
- DEPTH, 256, number of 64-bit words; power of two, ≥2.
- BASE_ADDR, 64'h0, byte address of word 0; 8-byte aligned.
- SECURE_ONLY, 0, when 1 any access with prot[1]=1 is rejected with error response.

Ports:
- aclk  in  1  clock; all logic on posedge.
- arst  in  1  reset, asynchronous assert, active-low (0 = in reset).
- awaddr  in  64  write byte address.
- awvalid  in  1  write address valid.
- awid  in  4  write ID; accepted, unused (bus has no BID).
- awprot  in  3  write protection.
- awready  out  1  write address accept.
- wvalid  in  1  write data valid.
- wdata  in  64  write data.
- wstrb  in  8  byte enables; bit i covers wdata[8i+7:8i].
- wready  out  1  write data accept.
- bvalid  out  1  write response valid.
- bresp  out  1  0 = OKAY, 1 = error.
- bready  in  1  write response accept.
- araddr  in  64  read byte address.
- arid  in  4  read ID.
- arvalid  in  1  read address valid.
- arprot  in  3  read protection.
- arready  out  1  read address accept.
- rvalid  out  1  read data valid.
- rdata  out  64  read data.
- rid  out  4  echo of arid.
- rresp  out  1  0 = OKAY, 1 = error.
- rready  in  1  read data accept.

Behaviour:
- **Reset (arst = 0):** all outputs are 0 immediately. Pending AW/W/AR/B/R state is discarded, including mid-transaction. Memory contents are not reset.
  - First rising aclk after release: awready, wready and arready go to 1.
- **Handshake:** a transfer occurs on a posedge with valid && ready. Payload is ignored while valid = 0.
- **Write buffers:** AW and W each have a one-entry holding register.
  - awready = !aw_full; wready = !w_full.
  - AW and W may arrive in either order, with any gap between them.
- **Write commit:** occurs on the edge where aw_full && w_full && (!bvalid || bready).
  - Commit also happens on the handshake edge itself if both are captured that cycle and B is free.
  - At commit, both buffers are cleared, and bvalid = 1, bresp are registered.
  - Minimum latency: AW and W accepted on edge N gives bvalid on edge N+1.
- **Address decode:** off = addr − BASE_ADDR; idx = off[..:3]; addr[2:0] are ignored.
  - Error if addr < BASE_ADDR, if idx ≥ DEPTH, or if (SECURE_ONLY && prot[1]).
  - Error write: memory is untouched and bresp = 1.
  - OK write: bytes with wstrb[i] = 1 are updated. wstrb = 0 is OKAY with no change.
- **B channel:** bvalid and bresp are held until bready. bvalid drops on the edge where bready = 1 unless a new commit occurs on the same edge. Back-to-back writes sustain one write per cycle.
- **Read path:** arready = !rvalid || rready.
  - AR accepted on edge N gives rvalid, rdata, rid = arid, rresp on edge N+1.
  - Error read: rdata = 0, rresp = 1.
  - rdata, rid and rresp are stable while rvalid && !rready. Throughput is 1 read per cycle with rready held at 1.
- **Read/write collision:** a read accepted on the same edge as a write commit to the same idx returns the pre-write data. Any later read returns the new data.
- **Channel independence:** the read and write channels are fully independent. Neither stalls the other.

Test Plan:
- **Basic write/read:** AW 0x10 and W 0x1122334455667788, strb 0xFF, same cycle; then AR 0x10, id 5 -> bvalid next cycle with bresp 0; rvalid next cycle with rdata 0x1122334455667788, rid 5, rresp 0.
- **Byte strobes and order:** W (wdata 0xAAAA…AA, strb 0x0F) arrives 3 cycles before AW 0x10 -> awready stays 1 and wready = 0 until AW arrives; readback of 0x10 = 0x11223344AAAAAAAA.
- **Out of range:** AW and W to BASE_ADDR + 8·DEPTH; AR 0x0 with arprot = 3'b010 and SECURE_ONLY = 1 -> bresp = 1 with memory unchanged; rresp = 1 with rdata = 0.
- **Backpressure:** bready = 0 for 4 cycles after a write; 2nd AW/W pair sent -> both captured, awready = wready = 0 until bready, bvalid held with stable bresp; rready = 0 -> arready = 0 and rdata/rid stable.
- **Streaming and collision:** 8 back-to-back AR with rready = 1 -> 8 consecutive rvalid beats with in-order rid; read issued on the commit edge of a write to the same word -> old data returned.
- **Reset mid-operation:** arst = 0 while bvalid = 1 and an AW is buffered -> bvalid = 0 immediately; after release, no stale B response and awready = 1.
